// File: rtl/hist_bin_streamer.sv
// Per-frame 256-bin luminance histogram on the pixel clock, streamed to the CPU
// one bin at a time over a 4-phase ready/saved handshake, clearing each bin on acknowledge.
module hist_bin_streamer #(
    parameter int BIN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  lum_i,
    input  logic        dv_i,
    input  logic        vs_i,
    input  logic        hist_bin_saved,
    output logic [15:0] hist_bin_data,
    output logic        hist_bin_ready,
    output logic        hist_busy
);
    // state    | meaning
    // CLEAR    | zero the bin RAM, one address per cycle
    // WAIT_VS  | idle until the next frame boundary
    // ACCUM    | count pixels of the current frame
    // DRAIN    | let the read-modify-write pipeline retire
    // DUMP_RD  | read bin[idx] into the output register
    // DUMP_HI  | hist_bin_ready high, wait for acknowledge
    // DUMP_LO  | hist_bin_ready low, wait for acknowledge release
    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        WAIT_VS = 3'd1,
        ACCUM   = 3'd2,
        DRAIN   = 3'd3,
        DUMP_RD = 3'd4,
        DUMP_HI = 3'd5,
        DUMP_LO = 3'd6
    } state_t;

    localparam logic [BIN_W-1:0] BIN_MAX = {BIN_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       clr_addr;
    logic [7:0]       idx;
    logic             drain_cnt;
    logic             vs_q;
    logic             vs_rise_q;
    logic             sync_q;
    logic             saved_s;
    logic             s1_vld;
    logic             s2_vld;
    logic [7:0]       s1_addr;
    logic [7:0]       s2_addr;
    logic [BIN_W-1:0] s2_data;
    logic [BIN_W-1:0] rd_q;
    logic [BIN_W-1:0] mem [0:255];

    logic             pix_acc;
    logic             rd_en;
    logic [7:0]       rd_addr;
    logic             we;
    logic [7:0]       wr_addr;
    logic [BIN_W-1:0] wr_data;
    logic [BIN_W-1:0] fwd_val;
    logic [BIN_W-1:0] inc_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == 8'd255) state_nxt = WAIT_VS;
            WAIT_VS: if (vs_rise_q) state_nxt = ACCUM;
            ACCUM:   if (vs_rise_q) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 1'b0) state_nxt = DUMP_RD;
            DUMP_RD: state_nxt = DUMP_HI;
            DUMP_HI: if (saved_s) state_nxt = DUMP_LO;
            DUMP_LO: if (!saved_s) state_nxt = (idx == 8'd255) ? WAIT_VS : DUMP_RD;
            default: state_nxt = CLEAR;
        endcase
    end

    // The edge pulse is registered, so the pixel beside the vs_i rise still counts
    // while the one in the following cycle is dropped.
    assign pix_acc = (state == ACCUM) && dv_i && !vs_rise_q;
    assign rd_en   = (state == ACCUM) || (state == DUMP_RD);
    assign rd_addr = (state == ACCUM) ? lum_i : idx;

    // The stage-2 register holds the value written on the same edge the stage-1
    // read sampled, which a read-first RAM cannot return.
    assign fwd_val = (s2_vld && (s2_addr == s1_addr)) ? s2_data : rd_q;
    assign inc_val = (fwd_val == BIN_MAX) ? BIN_MAX : fwd_val + BIN_W'(1);

    always_comb begin
        we      = 1'b0;
        wr_addr = s1_addr;
        wr_data = inc_val;
        if (state == CLEAR) begin
            we      = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (s1_vld) begin
            we      = 1'b1;
        end else if ((state == DUMP_HI) && saved_s) begin
            we      = 1'b1;
            wr_addr = idx;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q      <= 1'b0;
            vs_rise_q <= 1'b0;
            sync_q    <= 1'b0;
            saved_s   <= 1'b0;
            s1_vld    <= 1'b0;
            s1_addr   <= '0;
            s2_vld    <= 1'b0;
            s2_addr   <= '0;
            s2_data   <= '0;
            rd_q      <= '0;
            clr_addr  <= '0;
            drain_cnt <= 1'b1;
            idx       <= '0;
        end else begin
            vs_q      <= vs_i;
            vs_rise_q <= vs_i & ~vs_q;
            sync_q    <= hist_bin_saved;
            saved_s   <= sync_q;
            s1_vld    <= pix_acc;
            if (pix_acc) s1_addr <= lum_i;
            s2_vld    <= s1_vld;
            if (s1_vld) begin
                s2_addr <= s1_addr;
                s2_data <= inc_val;
            end
            if (rd_en) rd_q <= mem[rd_addr];
            if (state == CLEAR) clr_addr <= clr_addr + 8'd1;
            if (state != DRAIN)   drain_cnt <= 1'b1;
            else if (drain_cnt)   drain_cnt <= 1'b0;
            if (state == DRAIN) idx <= '0;
            else if ((state == DUMP_LO) && !saved_s && (idx != 8'd255)) idx <= idx + 8'd1;
        end
    end

    always_comb begin
        hist_bin_data            = '0;
        hist_bin_data[BIN_W-1:0] = rd_q;
    end

    assign hist_bin_ready = (state == DUMP_HI);
    assign hist_busy      = !((state == WAIT_VS) || (state == ACCUM));

endmodule

// File: tb/tb_hist_bin_streamer.sv
// Bench for hist_bin_streamer: 16-bit and 4-bit instances share stimulus and are
// checked against a per-frame pixel-count model, clamped to each bin width.
module tb_hist_bin_streamer;
    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [7:0]  lum_i = '0;
    logic        dv_i  = 1'b0;
    logic        vs_i  = 1'b0;
    logic        saved = 1'b0;
    logic [15:0] data16, data4;
    logic        ready16, ready4, busy16, busy4;

    int n_pass = 0;
    int n_tot  = 0;
    int cnt   [256];
    int got16 [256];
    int got4  [256];
    int seq2  [13] = '{5, 5, 200, 5, 5, 5, 200, 5, 5, 5, 200, 5, 5};

    typedef struct {
        logic [7:0] lum;
        int         n;
        int         exp16;
        int         exp4;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    hist_bin_streamer #(.BIN_W(16)) dut16 (
        .clk(clk), .rst(rst), .lum_i(lum_i), .dv_i(dv_i), .vs_i(vs_i),
        .hist_bin_saved(saved), .hist_bin_data(data16),
        .hist_bin_ready(ready16), .hist_busy(busy16)
    );

    hist_bin_streamer #(.BIN_W(4)) dut4 (
        .clk(clk), .rst(rst), .lum_i(lum_i), .dv_i(dv_i), .vs_i(vs_i),
        .hist_bin_saved(saved), .hist_bin_data(data4),
        .hist_bin_ready(ready4), .hist_busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic int sat(input int c, input int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) cnt[i] = 0;
    endtask

    task automatic pix(input logic [7:0] v, input bit dv);
        lum_i = v;
        dv_i  = dv;
        if (dv) cnt[v]++;
        tick();
    endtask

    task automatic step(input bit noisy);
        if (noisy) begin
            dv_i  = 1'b1;
            lum_i = 8'd3;
            vs_i  = ~vs_i;
        end
        tick();
    endtask

    task automatic check_clear();
        for (int k = 1; k < 256; k++) begin
            tick();
            chk($sformatf("clear_busy[%0d]", k), int'(busy16), 1);
            chk($sformatf("clear_ready[%0d]", k), int'(ready16), 0);
        end
        tick();
        chk("clear_done_busy16", int'(busy16), 0);
        chk("clear_done_busy4", int'(busy4), 0);
    endtask

    task automatic start_frame();
        dv_i = 1'b0;
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    // extra: pixel beside the terminating vs rise (counted); late: the next cycle (not counted)
    task automatic end_frame(input bit extra, input logic [7:0] ev, input logic [7:0] late);
        vs_i  = 1'b1;
        dv_i  = extra;
        lum_i = ev;
        if (extra) cnt[ev]++;
        tick();
        dv_i  = 1'b1;
        lum_i = late;
        tick();
        dv_i = 1'b0;
        vs_i = 1'b0;
        tick();
        tick();
        chk("vs_to_ready_early", int'(ready16), 0);
        tick();
        chk("vs_to_ready_4cyc", int'(ready16), 1);
    endtask

    task automatic dump(input int dly, input bit noise, input int stop_at);
        bit noisy;
        int w;
        for (int i = 0; i < 256; i++) begin
            noisy = noise && (i < 200);
            if (noise && (i == 200)) begin
                dv_i = 1'b0;
                vs_i = 1'b0;
            end
            w = 0;
            while (!ready16 && (w < 40)) begin
                step(noisy);
                w++;
            end
            if (!ready16) begin
                chk($sformatf("ready_timeout[%0d]", i), 0, 1);
                return;
            end
            if (i > 0) chk("release_latency", int'(w <= 4), 1);
            if (i == 0) chk("dump_busy", int'(busy16), 1);
            if (i == stop_at) return;
            chk($sformatf("bin16_first[%0d]", i), int'(data16), sat(cnt[i], 16));
            for (int d = 0; d < dly; d++) step(noisy);
            chk($sformatf("bin16[%0d]", i), int'(data16), sat(cnt[i], 16));
            chk($sformatf("bin4[%0d]", i), int'(data4), sat(cnt[i], 4));
            chk($sformatf("ready4[%0d]", i), int'(ready4), 1);
            got16[i] = int'(data16);
            got4[i]  = int'(data4);
            saved = 1'b1;
            w = 0;
            while (ready16 && (w < 10)) begin
                step(noisy);
                w++;
            end
            chk($sformatf("ack_latency[%0d]", i), int'((w <= 3) && !ready16), 1);
            saved = 1'b0;
        end
        dv_i = 1'b0;
        vs_i = 1'b0;
        repeat (5) tick();
        chk("dump_end_ready", int'(ready16), 0);
        chk("dump_end_busy16", int'(busy16), 0);
        chk("dump_end_busy4", int'(busy4), 0);
        clear_model();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] r;
        vecs[0] = '{8'd5,   10, 10, 10};
        vecs[1] = '{8'd9,   20, 20, 15};
        vecs[2] = '{8'd255, 16, 16, 15};
        vecs[3] = '{8'd0,   15, 15, 15};
        vecs[4] = '{8'd128,  3,  3,  3};
        clear_model();

        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_ready16", int'(ready16), 0);
        chk("rst_data16", int'(data16), 0);
        chk("rst_busy16", int'(busy16), 1);
        chk("rst_ready4", int'(ready4), 0);
        chk("rst_data4", int'(data4), 0);
        chk("rst_busy4", int'(busy4), 1);
        rst = 1'b0;
        check_clear();

        // sparse values, slow consumer
        start_frame();
        for (int k = 0; k < 13; k++) begin
            pix(8'(seq2[k]), 1'b1);
            pix(8'd200, 1'b0);
        end
        end_frame(1'b0, 8'd0, 8'd5);
        dump(5, 1'b0, 256);
        chk("t2_bin5", got16[5], 10);
        chk("t2_bin200", got16[200], 3);

        // long run of one value, then alternating values
        start_frame();
        repeat (1000) pix(8'd77, 1'b1);
        for (int k = 0; k < 8; k++) pix((k % 2 == 0) ? 8'd1 : 8'd2, 1'b1);
        end_frame(1'b0, 8'd0, 8'd77);
        dump(1, 1'b0, 256);
        chk("t3_bin77", got16[77], 1000);
        chk("t3_bin77_w4", got4[77], 15);
        chk("t3_bin1", got16[1], 4);
        chk("t3_bin2", got16[2], 4);

        for (int k = 0; k < 5; k++) begin
            start_frame();
            repeat (vecs[k].n) pix(vecs[k].lum, 1'b1);
            end_frame(1'b0, 8'd0, vecs[k].lum);
            dump(1, 1'b0, 256);
            chk($sformatf("vec%0d_bin16", k), got16[vecs[k].lum], vecs[k].exp16);
            chk($sformatf("vec%0d_bin4", k), got4[vecs[k].lum], vecs[k].exp4);
        end

        // pixel beside the terminating edge counts, the next one does not
        start_frame();
        pix(8'd60, 1'b1);
        end_frame(1'b1, 8'd60, 8'd61);
        dump(0, 1'b0, 256);
        chk("edge_same_cycle", got16[60], 2);
        chk("edge_late_cycle", got16[61], 0);

        // pixels and vs edges during a dump are ignored
        start_frame();
        repeat (3) pix(8'd7, 1'b1);
        end_frame(1'b0, 8'd0, 8'd7);
        dump(1, 1'b1, 256);
        start_frame();
        pix(8'd4, 1'b1);
        pix(8'd4, 1'b1);
        end_frame(1'b0, 8'd0, 8'd4);
        dump(2, 1'b0, 256);
        chk("t5_bin3", got16[3], 0);
        chk("t5_bin4", got16[4], 2);

        repeat (3) begin
            start_frame();
            n = $urandom_range(40, 200);
            for (int k = 0; k < n; k++) begin
                r = ($urandom % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                pix(r, ($urandom % 4) != 0);
            end
            end_frame(1'($urandom % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            dump($urandom_range(0, 3), 1'b0, 256);
        end

        // reset while bin 100 is presented
        start_frame();
        repeat (6) pix(8'd50, 1'b1);
        end_frame(1'b0, 8'd0, 8'd50);
        dump(1, 1'b0, 100);
        chk("t6_ready_before", int'(ready16), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_ready16", int'(ready16), 0);
        chk("t6_rst_ready4", int'(ready4), 0);
        chk("t6_rst_busy", int'(busy16), 1);
        chk("t6_rst_data", int'(data16), 0);
        saved = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
        check_clear();
        start_frame();
        pix(8'd0, 1'b1);
        end_frame(1'b0, 8'd0, 8'd0);
        dump(1, 1'b0, 256);
        chk("t6_bin0", got16[0], 1);
        chk("t6_bin50", got16[50], 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
